// File: rtl/sumador_acumulador_selectivo.sv
// ============================================================================
//  Module   : sumador_acumulador_selectivo
//  Purpose  : Registered selective adder/accumulator with sticky overflow.
//             Define SUMADOR_ACUM_SAT_EN to saturate instead of wrap on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_acumulador_selectivo #(
  parameter int NB_DATA = 3,
  parameter int NB_ACC  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [2:0]         i_sel,
  input  logic [NB_DATA-1:0] i_data1,
  input  logic [NB_DATA-1:0] i_data2,
  output logic [NB_ACC-1:0]  o_suma,
  output logic               o_valid,
  output logic               o_ovf
);

  localparam logic [2:0] c_SEL_LD_D2   = 3'b000;
  localparam logic [2:0] c_SEL_LD_SUM  = 3'b001;
  localparam logic [2:0] c_SEL_LD_D1   = 3'b010;
  localparam logic [2:0] c_SEL_LD_ZERO = 3'b011;
  localparam logic [2:0] c_SEL_AC_D1   = 3'b100;
  localparam logic [2:0] c_SEL_AC_D2   = 3'b101;
  localparam logic [2:0] c_SEL_AC_SUM  = 3'b110;
  localparam logic [2:0] c_SEL_HOLD    = 3'b111;

  logic [NB_ACC-1:0]  r_acc;
  logic               r_ovf;
  logic               r_valid;

  logic [NB_DATA:0]   w_pair_sum;
  logic [NB_ACC-1:0]  w_d1_ext;
  logic [NB_ACC-1:0]  w_d2_ext;
  logic [NB_ACC-1:0]  w_sum_ext;
  logic [NB_ACC-1:0]  w_term;
  logic               w_is_acc;
  logic [NB_ACC:0]    w_acc_wide;
  logic [NB_ACC-1:0]  w_acc_next;
  logic               w_ovf_next;

  assign w_pair_sum = {1'b0, i_data1} + {1'b0, i_data2};
  assign w_d1_ext   = NB_ACC'(i_data1);
  assign w_d2_ext   = NB_ACC'(i_data2);
  assign w_sum_ext  = NB_ACC'(w_pair_sum);

  always_comb begin
    w_term   = '0;
    w_is_acc = 1'b0;
    case (i_sel)
      c_SEL_AC_D1:  begin w_term = w_d1_ext;  w_is_acc = 1'b1; end
      c_SEL_AC_D2:  begin w_term = w_d2_ext;  w_is_acc = 1'b1; end
      c_SEL_AC_SUM: begin w_term = w_sum_ext; w_is_acc = 1'b1; end
      default:      begin w_term = '0;        w_is_acc = 1'b0; end
    endcase
  end

  // One extra bit catches the carry out of the accumulator.
  assign w_acc_wide = {1'b0, r_acc} + {1'b0, w_term};

  always_comb begin
    w_acc_next = r_acc;
    w_ovf_next = r_ovf;
    if (i_valid) begin
      case (i_sel)
        c_SEL_LD_D2:   begin w_acc_next = w_d2_ext;  w_ovf_next = 1'b0; end
        c_SEL_LD_SUM:  begin w_acc_next = w_sum_ext; w_ovf_next = 1'b0; end
        c_SEL_LD_D1:   begin w_acc_next = w_d1_ext;  w_ovf_next = 1'b0; end
        c_SEL_LD_ZERO: begin w_acc_next = '0;        w_ovf_next = 1'b0; end
        c_SEL_HOLD:    begin w_acc_next = r_acc;     w_ovf_next = r_ovf; end
        default: begin
          if (w_is_acc && w_acc_wide[NB_ACC]) begin
            w_ovf_next = 1'b1;
`ifdef SUMADOR_ACUM_SAT_EN
            w_acc_next = '1;
`else
            w_acc_next = w_acc_wide[NB_ACC-1:0];
`endif
          end else begin
            w_acc_next = w_acc_wide[NB_ACC-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_valid <= i_valid;
    end
  end

  assign o_suma  = r_acc;
  assign o_ovf   = r_ovf;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sumador_acumulador_selectivo.sv
// ============================================================================
//  Module   : tb_sumador_acumulador_selectivo
//  Purpose  : Directed self-checking bench for sumador_acumulador_selectivo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sumador_acumulador_selectivo;

  localparam int NB_DATA = 3;
  localparam int NB_ACC  = 6;

  logic               clk;
  logic               rst;
  logic               valid_in;
  logic [2:0]         sel;
  logic [NB_DATA-1:0] d1;
  logic [NB_DATA-1:0] d2;
  logic [NB_ACC-1:0]  suma;
  logic               valid_out;
  logic               ovf;

  int n_tests;
  int n_fail;

  sumador_acumulador_selectivo #(
    .NB_DATA(NB_DATA),
    .NB_ACC (NB_ACC)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid_in),
    .i_sel  (sel),
    .i_data1(d1),
    .i_data2(d2),
    .o_suma (suma),
    .o_valid(valid_out),
    .o_ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operation, step one edge, sample 1 time unit later.
  task automatic do_op(input logic v, input logic [2:0] s,
                       input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b);
    valid_in = v;
    sel      = s;
    d1       = a;
    d2       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int e_suma, input int e_valid, input int e_ovf);
    check({tag, ".suma"},  32'(suma),      32'(e_suma));
    check({tag, ".valid"}, 32'(valid_out), 32'(e_valid));
    check({tag, ".ovf"},   32'(ovf),       32'(e_ovf));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    sel      = 3'b000;
    d1       = '0;
    d2       = '0;

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Load operations
    do_op(1'b1, 3'b000, 3'd5, 3'd6); expect_out("ld000", 6,  1, 0);
    do_op(1'b1, 3'b001, 3'd5, 3'd6); expect_out("ld001", 11, 1, 0);
    do_op(1'b1, 3'b010, 3'd5, 3'd6); expect_out("ld010", 5,  1, 0);
    do_op(1'b1, 3'b011, 3'd5, 3'd6); expect_out("ld011", 0,  1, 0);
    do_op(1'b0, 3'b001, 3'd5, 3'd6); expect_out("idle0", 0,  0, 0);

    // Accumulate chain
    do_op(1'b1, 3'b001, 3'd7, 3'd7); expect_out("chain0", 14, 1, 0);
    do_op(1'b1, 3'b110, 3'd7, 3'd7); expect_out("chain1", 28, 1, 0);
    do_op(1'b1, 3'b110, 3'd7, 3'd7); expect_out("chain2", 42, 1, 0);
    do_op(1'b1, 3'b110, 3'd7, 3'd7); expect_out("chain3", 56, 1, 0);

    // Overflow, sticky flag, clear by load
`ifdef SUMADOR_ACUM_SAT_EN
    do_op(1'b1, 3'b110, 3'd7, 3'd7); expect_out("ovf",    63, 1, 1);
    do_op(1'b1, 3'b100, 3'd1, 3'd0); expect_out("sticky", 63, 1, 1);
`else
    do_op(1'b1, 3'b110, 3'd7, 3'd7); expect_out("ovf",    6,  1, 1);
    do_op(1'b1, 3'b100, 3'd1, 3'd0); expect_out("sticky", 7,  1, 1);
`endif
    do_op(1'b1, 3'b011, 3'd1, 3'd0); expect_out("ovfclr", 0,  1, 0);

    // Single-operand accumulates: 14 + d2(2) + d1(4) = 20
    do_op(1'b1, 3'b001, 3'd7, 3'd7); expect_out("g_ld",  14, 1, 0);
    do_op(1'b1, 3'b101, 3'd0, 3'd2); expect_out("g_ac2", 16, 1, 0);
    do_op(1'b1, 3'b100, 3'd4, 3'd0); expect_out("g_ac1", 20, 1, 0);

    // Gating: invalid ops must not touch the accumulator
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 3'b011, 3'd3, 3'd3);
      expect_out($sformatf("gate%0d", i), 20, 0, 0);
    end
    do_op(1'b1, 3'b111, 3'd3, 3'd3); expect_out("hold",  20, 1, 0);
    do_op(1'b0, 3'b111, 3'd3, 3'd3); expect_out("hold1", 20, 0, 0);

    // Build acc=25 with ovf=1 (wrap) or acc=63 with ovf=1 (sat), then reset mid-burst
    do_op(1'b1, 3'b001, 3'd7, 3'd7);
    do_op(1'b1, 3'b110, 3'd7, 3'd7);
    do_op(1'b1, 3'b110, 3'd7, 3'd7);
    do_op(1'b1, 3'b110, 3'd7, 3'd7);
    do_op(1'b1, 3'b110, 3'd7, 3'd7);
    do_op(1'b1, 3'b110, 3'd7, 3'd7);
    do_op(1'b1, 3'b100, 3'd5, 3'd0);
`ifdef SUMADOR_ACUM_SAT_EN
    expect_out("pre_rst", 63, 1, 1);
`else
    expect_out("pre_rst", 25, 1, 1);
`endif
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0);
    do_op(1'b1, 3'b001, 3'd3, 3'd4);
    expect_out("rst_hold", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 3'b001, 3'd3, 3'd4); expect_out("post_rst", 7, 1, 0);
    do_op(1'b0, 3'b000, 3'd0, 3'd0); expect_out("post_idle", 7, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000");
    $fatal(1);
  end

endmodule

`default_nettype wire
